// File: rtl/stopwatch_pkg.sv
// Shared encodings and helpers for the lap stopwatch slice.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_EXP   = 2'b11
    } status_e;

    localparam logic [5:0] SEC_MAX   = 6'd59;
    localparam logic       MODE_UP   = 1'b0;
    localparam logic       MODE_DOWN = 1'b1;

    function automatic logic [5:0] clamp_sec(input logic [5:0] s);
        return (s > SEC_MAX) ? SEC_MAX : s;
    endfunction

endpackage

// File: rtl/lap_fifo.sv
// Small circular FIFO holding captured lap times; head is read straight from storage.
module lap_fifo #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_ok, push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    // A push into a full FIFO is only allowed when the head leaves on the same edge.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_ok) rd_q <= rd_q + 1'b1;
            if (push_ok && !pop_ok) count_q <= count_q + 1'b1;
            else if (!push_ok && pop_ok) count_q <= count_q - 1'b1;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/lap_stopwatch.sv
// Up/down min:sec timer with prescaler, preload, countdown expiry and lap capture FIFO.
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1,
    parameter int unsigned MIN_W     = 8,
    parameter int unsigned LAP_DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(LAP_DEPTH + 1),
    localparam int unsigned PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             mode,
    input  logic             load,
    input  logic [MIN_W-1:0] load_min,
    input  logic [5:0]       load_sec,
    input  logic             lap,
    input  logic             lap_rd,
    output logic [MIN_W-1:0] minutes,
    output logic [5:0]       seconds,
    output logic [1:0]       status,
    output logic             tick,
    output logic             expired,
    output logic             lap_valid,
    output logic [MIN_W-1:0] lap_min,
    output logic [5:0]       lap_sec,
    output logic [CNT_W-1:0] lap_count,
    output logic             lap_overflow
);

    status_e          status_q, status_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [5:0]       sec_q, sec_d;
    logic [PS_W-1:0]  presc_q, presc_d;
    logic             tick_q, tick_d, expired_q, expired_d, ovf_q, ovf_d;
    logic             load_ok, lap_ok, fifo_full, fifo_empty;
    logic [MIN_W+5:0] fifo_head;

    assign load_ok = load && (status_q == ST_IDLE || status_q == ST_PAUSE);
    assign lap_ok  = lap && (status_q == ST_RUN || status_q == ST_PAUSE);

    always_comb begin
        status_d  = status_q;
        min_d     = min_q;
        sec_d     = sec_q;
        presc_d   = presc_q;
        tick_d    = 1'b0;
        expired_d = 1'b0;
        ovf_d     = ovf_q;
        if (lap_ok && fifo_full && !(lap_rd && !fifo_empty)) ovf_d = 1'b1;
        if (clear) begin
            status_d = ST_IDLE;
            min_d    = '0;
            sec_d    = '0;
            presc_d  = '0;
            ovf_d    = 1'b0;
        end else if (load_ok) begin
            min_d   = load_min;
            sec_d   = clamp_sec(load_sec);
            presc_d = '0;
        end else if (stop) begin
            if (status_q == ST_RUN) status_d = ST_PAUSE;
        end else if (start && status_q == ST_IDLE) begin
            if (!(mode == MODE_DOWN && min_q == '0 && sec_q == '0)) status_d = ST_RUN;
        end else if (start && status_q == ST_PAUSE) begin
            status_d = ST_RUN;
        end else if (status_q == ST_RUN) begin
            if (presc_q == PS_W'(TICK_DIV - 1)) begin
                presc_d = '0;
                tick_d  = 1'b1;
                if (mode == MODE_UP) begin
                    if (sec_q == SEC_MAX) begin
                        sec_d = '0;
                        min_d = min_q + 1'b1;
                    end else begin
                        sec_d = sec_q + 1'b1;
                    end
                end else begin
                    if (sec_q == '0) begin
                        sec_d = SEC_MAX;
                        min_d = min_q - 1'b1;
                    end else begin
                        sec_d = sec_q - 1'b1;
                    end
                    if (min_d == '0 && sec_d == '0) begin
                        status_d  = ST_EXP;
                        expired_d = 1'b1;
                    end
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q  <= ST_IDLE;
            min_q     <= '0;
            sec_q     <= '0;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            status_q  <= status_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            expired_q <= expired_d;
            ovf_q     <= ovf_d;
        end
    end

    lap_fifo #(
        .WIDTH(MIN_W + 6),
        .DEPTH(LAP_DEPTH)
    ) u_lap_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush_i(clear),
        .push_i (lap_ok),
        .pop_i  (lap_rd),
        .data_i ({min_q, sec_q}),
        .head_o (fifo_head),
        .count_o(lap_count),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign minutes      = min_q;
    assign seconds      = sec_q;
    assign status       = status_q;
    assign tick         = tick_q;
    assign expired      = expired_q;
    assign lap_valid    = !fifo_empty;
    assign lap_min      = fifo_head[MIN_W+5:6];
    assign lap_sec      = fifo_head[5:0];
    assign lap_overflow = ovf_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Randomised and directed check of lap_stopwatch against a total-seconds reference model.
module tb_lap_stopwatch;

    localparam int TICK_DIV  = 3;
    localparam int MIN_W     = 4;
    localparam int LAP_DEPTH = 4;
    localparam int CNT_W     = $clog2(LAP_DEPTH + 1);
    localparam int TOT       = (1 << MIN_W) * 60;

    logic             clk = 1'b0;
    logic             rst, start, stop, clear, mode, load, lap, lap_rd;
    logic [MIN_W-1:0] load_min;
    logic [5:0]       load_sec;
    logic [MIN_W-1:0] minutes, lap_min;
    logic [5:0]       seconds, lap_sec;
    logic [1:0]       status;
    logic             tick, expired, lap_valid, lap_overflow;
    logic [CNT_W-1:0] lap_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time as total seconds, FIFO as a queue of totals.
    int m_st, m_t, m_ps;
    bit m_tick, m_exp, m_ovf;
    int q[$];

    always #5 clk = ~clk;

    lap_stopwatch #(
        .TICK_DIV (TICK_DIV),
        .MIN_W    (MIN_W),
        .LAP_DEPTH(LAP_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .mode        (mode),
        .load        (load),
        .load_min    (load_min),
        .load_sec    (load_sec),
        .lap         (lap),
        .lap_rd      (lap_rd),
        .minutes     (minutes),
        .seconds     (seconds),
        .status      (status),
        .tick        (tick),
        .expired     (expired),
        .lap_valid   (lap_valid),
        .lap_min     (lap_min),
        .lap_sec     (lap_sec),
        .lap_count   (lap_count),
        .lap_overflow(lap_overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_t = 0; m_ps = 0; m_tick = 0; m_exp = 0; m_ovf = 0;
        q.delete();
    endtask

    task automatic model_step();
        bit lap_ok;
        int ls;
        lap_ok = lap && (m_st == 1 || m_st == 2);
        m_tick = 0;
        m_exp  = 0;
        if (clear) begin
            m_st = 0; m_t = 0; m_ps = 0; m_ovf = 0;
            q.delete();
            return;
        end
        if (lap_rd && q.size() > 0) void'(q.pop_front());
        if (lap_ok) begin
            if (q.size() < LAP_DEPTH) q.push_back(m_t);
            else m_ovf = 1;
        end
        if (load && (m_st == 0 || m_st == 2)) begin
            ls   = (int'(load_sec) > 59) ? 59 : int'(load_sec);
            m_t  = int'(load_min) * 60 + ls;
            m_ps = 0;
        end else if (stop) begin
            if (m_st == 1) m_st = 2;
        end else if (start && m_st == 0) begin
            if (!(mode && m_t == 0)) m_st = 1;
        end else if (start && m_st == 2) begin
            m_st = 1;
        end else if (m_st == 1) begin
            if (m_ps == TICK_DIV - 1) begin
                m_ps   = 0;
                m_tick = 1;
                if (!mode) m_t = (m_t + 1) % TOT;
                else begin
                    m_t = (m_t + TOT - 1) % TOT;
                    if (m_t == 0) begin
                        m_st  = 3;
                        m_exp = 1;
                    end
                end
            end else begin
                m_ps++;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("minutes", 32'(minutes), m_t / 60);
        check_eq("seconds", 32'(seconds), m_t % 60);
        check_eq("status", 32'(status), m_st);
        check_eq("tick", 32'(tick), 32'(m_tick));
        check_eq("expired", 32'(expired), 32'(m_exp));
        check_eq("lap_valid", 32'(lap_valid), 32'(q.size() > 0));
        check_eq("lap_count", 32'(lap_count), q.size());
        check_eq("lap_overflow", 32'(lap_overflow), 32'(m_ovf));
        if (q.size() > 0) begin
            check_eq("lap_min", 32'(lap_min), q[0] / 60);
            check_eq("lap_sec", 32'(lap_sec), q[0] % 60);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; clear = 0; load = 0; lap = 0; lap_rd = 0;
        load_min = '0; load_sec = '0;
    endtask

    initial begin
        int exp_cnt;
        int first_cap;
        idle_inputs();
        mode = 0;
        rst  = 1;
        model_reset();
        #2;
        compare_all();
        check_eq("rst_lap_min", 32'(lap_min), 0);
        check_eq("rst_lap_sec", 32'(lap_sec), 0);
        @(posedge clk);
        #1;
        rst = 0;

        // Up count: two ticks in six running cycles.
        start = 1; cycle(); start = 0;
        repeat (6) cycle();
        check_eq("up_seconds", 32'(seconds), 2);
        check_eq("up_status", 32'(status), 1);

        // Pause keeps the prescaler; resume ticks on the first counting edge.
        repeat (2) cycle();
        stop = 1; cycle(); stop = 0;
        repeat (10) cycle();
        check_eq("paused_status", 32'(status), 2);
        start = 1; cycle(); start = 0;
        check_eq("resume_no_tick", 32'(tick), 0);
        cycle();
        check_eq("resume_tick", 32'(tick), 1);
        check_eq("resume_seconds", 32'(seconds), 3);

        // Countdown from 0:03 to expiry.
        clear = 1; cycle(); clear = 0;
        mode = 1;
        start = 1; cycle(); start = 0;
        check_eq("down_zero_start_ignored", 32'(status), 0);
        load = 1; load_sec = 6'd3; cycle(); idle_inputs();
        start = 1; cycle(); start = 0;
        exp_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            cycle();
            exp_cnt += int'(expired);
        end
        check_eq("expired_status", 32'(status), 3);
        check_eq("expired_pulses", exp_cnt, 1);
        check_eq("expired_seconds", 32'(seconds), 0);
        start = 1; cycle(); start = 0;
        check_eq("expired_start_ignored", 32'(status), 3);
        clear = 1; cycle(); clear = 0;
        check_eq("clear_to_idle", 32'(status), 0);

        // Five laps into a four-deep FIFO.
        mode = 0;
        start = 1; cycle(); start = 0;
        first_cap = m_t;
        lap = 1; repeat (5) cycle(); lap = 0;
        check_eq("lap_count_full", 32'(lap_count), 4);
        check_eq("lap_overflow_set", 32'(lap_overflow), 1);
        check_eq("lap_head_first", 32'(lap_min) * 60 + 32'(lap_sec), first_cap);
        lap_rd = 1; repeat (4) cycle(); lap_rd = 0;
        check_eq("lap_drained", 32'(lap_valid), 0);

        // Minute wrap and seconds clamp.
        stop = 1; cycle(); stop = 0;
        load = 1; load_min = 4'd15; load_sec = 6'd59; cycle(); idle_inputs();
        start = 1; cycle(); start = 0;
        repeat (3) cycle();
        check_eq("wrap_minutes", 32'(minutes), 0);
        check_eq("wrap_seconds", 32'(seconds), 0);
        stop = 1; cycle(); stop = 0;
        load = 1; load_min = 4'd5; load_sec = 6'd63; cycle(); idle_inputs();
        check_eq("clamp_seconds", 32'(seconds), 59);
        clear = 1; cycle(); clear = 0;
        start = 1; stop = 1; cycle(); start = 0; stop = 0;
        check_eq("start_stop_idle", 32'(status), 0);

        // Asynchronous reset mid-count.
        start = 1; cycle(); start = 0;
        lap = 1; repeat (4) cycle(); lap = 0;
        #2 rst = 1;
        #1;
        check_eq("async_rst_seconds", 32'(seconds), 0);
        check_eq("async_rst_status", 32'(status), 0);
        check_eq("async_rst_lap_count", 32'(lap_count), 0);
        rst = 0;
        model_reset();

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            clear    = ($urandom_range(63) == 0);
            load     = ($urandom_range(15) == 0);
            stop     = ($urandom_range(7) == 0);
            start    = ($urandom_range(2) == 0);
            lap      = ($urandom_range(5) == 0);
            lap_rd   = ($urandom_range(4) == 0);
            load_min = MIN_W'($urandom);
            load_sec = 6'($urandom);
            if ($urandom_range(31) == 0) mode = ~mode;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
